// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcode encodings and the write-back FIFO state,
// plus occupancy step helpers used by the write-back stage.
package cpu_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_SUB  = 3'b011,
      OP_ADD  = 3'b100,
      OP_SHL  = 3'b101,
      OP_SHR  = 3'b110,
      OP_PASS = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } fifo_state_t;

   function automatic fifo_state_t state_inc(input fifo_state_t s);
      return (s == ST_EMPTY) ? ST_ONE : ST_FULL;
   endfunction

   function automatic fifo_state_t state_dec(input fifo_state_t s);
      return (s == ST_FULL) ? ST_ONE : ST_EMPTY;
   endfunction

endpackage

// File: rtl/wb_stage.sv
// Write-back stage: 2-entry FIFO between ALU and register file, flags updated on add.
// Optional forwarding of the youngest buffered entry with WB_STAGE_FWD_EN.
module wb_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [2:0]        IN_OP,
   input  logic [DATA_W-1:0] IN_RES,
   input  logic [1:0]        IN_OVF,
   input  logic              IN_ZF,
   input  logic [ADDR_W-1:0] IN_DST,
   output logic              RF_WE,
   output logic [ADDR_W-1:0] RF_ADDR,
   output logic [DATA_W-1:0] RF_DATA,
   input  logic              RF_READY,
   output logic              FLAG_Z,
`ifdef WB_STAGE_FWD_EN
   output logic [1:0]        FLAG_C,
   output logic              FWD_VALID,
   output logic [ADDR_W-1:0] FWD_ADDR,
   output logic [DATA_W-1:0] FWD_DATA
`else
   output logic [1:0]        FLAG_C
`endif
);

   fifo_state_t       state;
   logic              wr_ptr;
   logic              rd_ptr;
   logic [ADDR_W-1:0] addr_mem [2];
   logic [DATA_W-1:0] data_mem [2];
   logic              push;
   logic              pop;

   // When full, a slot frees up in the same cycle the register file takes the oldest entry.
   assign IN_READY = (state != ST_FULL) || RF_READY;
   assign RF_WE    = (state != ST_EMPTY);
   assign RF_ADDR  = addr_mem[rd_ptr];
   assign RF_DATA  = data_mem[rd_ptr];
   assign push     = IN_VALID && IN_READY;
   assign pop      = RF_WE && RF_READY;

`ifdef WB_STAGE_FWD_EN
   assign FWD_VALID = (state != ST_EMPTY);
   assign FWD_ADDR  = addr_mem[~wr_ptr];
   assign FWD_DATA  = data_mem[~wr_ptr];
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= ST_EMPTY;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         FLAG_Z   <= 1'b0;
         FLAG_C   <= 2'b00;
         // NOTE: the two storage slots are reset so RF_ADDR/RF_DATA read zero out of reset.
         addr_mem <= '{default: '0};
         data_mem <= '{default: '0};
      end else begin
         if (push) begin
            addr_mem[wr_ptr] <= IN_DST;
            data_mem[wr_ptr] <= IN_RES;
            wr_ptr           <= ~wr_ptr;
            if (IN_OP == OP_ADD) begin
               FLAG_Z <= IN_ZF;
               FLAG_C <= IN_OVF;
            end
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         unique case ({push, pop})
            2'b10:   state <= state_inc(state);
            2'b01:   state <= state_dec(state);
            default: state <= state;
         endcase
      end
   end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning ALU result width.
REQ-002 SHALL have parameter ADDR_W, default 3, meaning register-file index width.
REQ-003 SHALL provide: CLK  input  1  sole clock, all state on rising edge.
REQ-004 SHALL provide: RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide: IN_VALID  input  1  ALU result presented this cycle.
REQ-006 SHALL provide: IN_READY  output  1  stage can accept a result.
REQ-007 SHALL provide: IN_OP  input  3  ALU opcode that produced the result.
REQ-008 SHALL provide: IN_RES  input  DATA_W  ALU result.
REQ-009 SHALL provide: IN_OVF  input  2  ALU carry-out bits.
REQ-010 SHALL provide: IN_ZF  input  1  ALU zero flag.
REQ-011 SHALL provide: IN_DST  input  ADDR_W  destination register index.
REQ-012 SHALL provide: RF_WE  output  1  register-file write strobe.
REQ-013 SHALL provide: RF_ADDR  output  ADDR_W  register-file write index.
REQ-014 SHALL provide: RF_DATA  output  DATA_W  register-file write data.
REQ-015 SHALL provide: RF_READY  input  1  register file accepts the write this cycle.
REQ-016 SHALL provide: FLAG_Z  output  1 and FLAG_C  output  2  architectural flags for branch logic.

Function
REQ-017 SHALL buffer results in a 2-entry FIFO; accept when IN_VALID && IN_READY; retire when RF_WE && RF_READY.
REQ-018 SHALL implement states EMPTY, ONE, FULL: push-only advances one state, pop-only retreats one, push+pop holds.
REQ-019 SHALL drive IN_READY = 1 in EMPTY and ONE; in FULL, IN_READY = RF_READY (push accepted same cycle as pop).
REQ-020 SHALL drive RF_WE = 1 exactly when state != EMPTY, with RF_ADDR/RF_DATA from the oldest entry; no combinational path IN_* to RF_*.
REQ-021 SHALL give minimum latency of one cycle: a result accepted at edge N appears on RF_* in cycle N+1.
REQ-022 SHALL hold RF_ADDR/RF_DATA stable while RF_WE && !RF_READY.
REQ-023 SHALL update FLAG_Z and FLAG_C on acceptance (not retirement) only when IN_OP == 3'b100 (add); other opcodes leave flags unchanged.
REQ-024 SHALL maintain program order; write and read pointers are 1 bit and wrap 1 -> 0.
REQ-025 SHALL ignore IN_* when IN_VALID == 0; in FULL with RF_READY == 0 an offered result is not accepted and not lost upstream (IN_READY = 0).

Reset
REQ-026 SHALL on RESET asynchronously force state EMPTY, both pointers 0, RF_WE = 0, RF_ADDR = 0, RF_DATA = 0, FLAG_Z = 0, FLAG_C = 0, IN_READY = 1 after release.
REQ-027 SHALL discard any buffered entries when RESET asserts mid-operation; no write issues in the reset cycle.

Configuration
REQ-028 SHALL, with WB_STAGE_FWD_EN defined, add outputs FWD_VALID (1), FWD_ADDR (ADDR_W), FWD_DATA (DATA_W) presenting the youngest buffered entry, FWD_VALID = (state != EMPTY).
REQ-029 SHALL, without WB_STAGE_FWD_EN, omit those ports and all forwarding logic.

Structure
REQ-030 SHALL take the ALU opcode encodings (including add = 3'b100) and the FIFO state enum from the shared cpu package.
REQ-031 SHALL be a single module with no sub-modules; FIFO storage inline.

Verification
REQ-032 SHALL cover: EMPTY, push RES=8'h5A DST=3, RF_READY=1 -> next cycle RF_WE=1, RF_ADDR=3, RF_DATA=8'h5A, then EMPTY.
REQ-033 SHALL cover: RF_READY=0, push 8'h11 then 8'h22 -> FULL, IN_READY=0; RF_READY=1 -> writes 8'h11 then 8'h22 in order.
REQ-034 SHALL cover: FULL, RF_READY=1, push 8'h33 same cycle -> state stays FULL, order 11,22,33 preserved.
REQ-035 SHALL cover: push OP=3'b100 OVF=2'b01 ZF=1, then OP=3'b000 ZF=0 -> FLAG_C=2'b01, FLAG_Z=1 held after second push.
REQ-036 SHALL cover: FULL, assert RESET mid-cycle -> RF_WE drops immediately, no further writes, IN_READY=1 after release.
REQ-037 SHALL cover (WB_STAGE_FWD_EN): ONE holding DST=5 RES=8'hA0, push DST=6 RES=8'hB1 -> FWD_ADDR=6, FWD_DATA=8'hB1.
